// File: rtl/demux_1x6_router.sv
// Registered 1-to-6 byte router with broadcast and illegal-code drop.
// Each channel owns a one-entry holding register; illegal codes are counted.
module demux_1x6_router #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_ctrl,
    output logic [5:0]         out_valid,
    input  logic [5:0]         out_ready,
    output logic [6*WIDTH-1:0] out_data,
    output logic [ERR_W-1:0]   err_count,
    output logic               err_pulse
);

    logic [5:0]       full;
    logic [5:0]       free;
    logic [5:0]       wr;
    logic [7:0]       ready_sel;
    logic             accept;
    logic             illegal;
    logic [WIDTH-1:0] data_q [6];

    assign free      = ~full | out_ready;
    // Code 6 always swallows; code 7 needs every channel free at once.
    assign ready_sel = {&free, 1'b1, free};
    assign in_ready  = ready_sel[in_ctrl];
    assign accept    = in_valid && in_ready;
    assign illegal   = accept && (in_ctrl == 3'd6);

    always_comb begin
        wr = '0;
        for (int n = 0; n < 6; n++) begin
            wr[n] = accept && ((in_ctrl == 3'(n)) || (in_ctrl == 3'd7));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full      <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
            for (int n = 0; n < 6; n++) begin
                data_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 6; n++) begin
                if (wr[n]) begin
                    data_q[n] <= in_data;
                    full[n]   <= 1'b1;
                end else if (out_ready[n]) begin
                    full[n] <= 1'b0;
                end
            end
            err_pulse <= illegal;
            if (illegal && !(&err_count)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign out_valid = full;

    always_comb begin
        out_data = '0;
        for (int n = 0; n < 6; n++) begin
            out_data[n*WIDTH +: WIDTH] = data_q[n];
        end
    end

endmodule

// File: tb/tb_demux_1x6_router.sv
// Bench for demux_1x6_router: directed scenarios plus random traffic
// compared every cycle against a behavioural channel model.
module tb_demux_1x6_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [2:0]  in_ctrl;
    logic [5:0]  out_ready;

    logic        in_ready_a, in_ready_b;
    logic [5:0]  out_valid_a, out_valid_b;
    logic [47:0] out_data_a, out_data_b;
    logic [7:0]  err_count_a;
    logic [1:0]  err_count_b;
    logic        err_pulse_a, err_pulse_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_1x6_router #(.WIDTH(8), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a),
        .err_count(err_count_a), .err_pulse(err_pulse_a)
    );

    demux_1x6_router #(.WIDTH(8), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b),
        .err_count(err_count_b), .err_pulse(err_pulse_b)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: six one-byte mailboxes and a count of dropped bytes.
    logic [5:0] m_full;
    logic [7:0] m_data [6];
    int         m_errn;
    logic       m_pulse;
    logic       started = 1'b0;
    int         pulses_b = 0;

    function automatic logic m_ready();
        logic all_free;
        all_free = 1'b1;
        for (int n = 0; n < 6; n++)
            if (m_full[n] && !out_ready[n]) all_free = 1'b0;
        if (in_ctrl == 3'd6) return 1'b1;
        if (in_ctrl == 3'd7) return all_free;
        return !m_full[in_ctrl] || out_ready[in_ctrl];
    endfunction

    always @(posedge clk) begin
        logic rdy;
        started <= 1'b1;
        if (!rst_n) begin
            m_full  <= '0;
            m_errn  <= 0;
            m_pulse <= 1'b0;
            for (int n = 0; n < 6; n++) m_data[n] <= 8'h00;
        end else begin
            rdy = m_ready();
            m_pulse <= in_valid && in_ctrl == 3'd6;
            if (in_valid && in_ctrl == 3'd6) m_errn <= m_errn + 1;
            for (int n = 0; n < 6; n++) begin
                if (in_valid && rdy && (in_ctrl == 3'(n) || in_ctrl == 3'd7)) begin
                    m_full[n] <= 1'b1;
                    m_data[n] <= in_data;
                end else if (m_full[n] && out_ready[n]) begin
                    m_full[n] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [47:0] exp_data;
        if (started) begin
            for (int n = 0; n < 6; n++) exp_data[n*8 +: 8] = m_data[n];
            if (rst_n) chk("in_ready", in_ready_a, m_ready());
            chk("out_valid", out_valid_a, m_full);
            chk("out_data", out_data_a, exp_data);
            chk("err_count", err_count_a, (m_errn > 255) ? 255 : m_errn);
            chk("err_pulse", err_pulse_a, m_pulse);
            chk("err_count_w2", err_count_b, (m_errn > 3) ? 3 : m_errn);
            chk("out_valid_w2", out_valid_b, m_full);
            if (err_pulse_b) pulses_b++;
        end
    end

    task automatic set(input logic v, input logic [2:0] c,
                       input logic [7:0] d, input logic [5:0] r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        rst_n = 1'b0;
        set(1'b0, 3'd0, 8'h00, 6'h00);
        step();
        step();
        chk("rst_valid", out_valid_a, 6'h00);
        chk("rst_data", out_data_a, 48'h0);
        chk("rst_err", err_count_a, 8'h00);
        chk("rst_pulse", err_pulse_a, 1'b0);
        rst_n = 1'b1;

        // Single route to channel 3
        set(1'b1, 3'd3, 8'hA5, 6'h00);
        chk("route_rdy", in_ready_a, 1'b1);
        step();
        set(1'b0, 3'd0, 8'h00, 6'b001000);
        chk("route_valid", out_valid_a, 6'b001000);
        chk("route_data", out_data_a[31:24], 8'hA5);
        step();
        chk("pop_valid", out_valid_a, 6'h00);

        // Back-pressure on channel 2
        set(1'b1, 3'd2, 8'h11, 6'h00);
        step();
        set(1'b1, 3'd2, 8'h22, 6'h00);
        chk("bp_rdy_lo", in_ready_a, 1'b0);
        step();
        chk("bp_hold", out_data_a[23:16], 8'h11);
        set(1'b1, 3'd2, 8'h22, 6'b000100);
        chk("bp_rdy_hi", in_ready_a, 1'b1);
        step();
        set(1'b1, 3'd0, 8'h33, 6'h00);
        chk("bp_new", out_data_a[23:16], 8'h22);
        chk("bp_valid", out_valid_a[2], 1'b1);
        chk("bp_ch0_rdy", in_ready_a, 1'b1);
        step();
        chk("bp_ch0", out_data_a[7:0], 8'h33);
        set(1'b0, 3'd0, 8'h00, 6'h3F);
        step();

        // Streaming to channel 5
        for (int i = 0; i < 10; i++) begin
            set(1'b1, 3'd5, 8'(i), 6'h3F);
            chk("strm_rdy", in_ready_a, 1'b1);
            step();
            chk("strm_data", out_data_a[47:40], 8'(i));
            chk("strm_valid", out_valid_a[5], 1'b1);
        end
        set(1'b0, 3'd0, 8'h00, 6'h3F);
        step();

        // Broadcast blocked by stalled channel 4
        set(1'b1, 3'd4, 8'h44, 6'h00);
        step();
        set(1'b1, 3'd7, 8'h5A, 6'h00);
        chk("bc_rdy_lo", in_ready_a, 1'b0);
        step();
        chk("bc_none", out_valid_a, 6'b010000);
        set(1'b1, 3'd7, 8'h5A, 6'b010000);
        chk("bc_rdy_hi", in_ready_a, 1'b1);
        step();
        set(1'b0, 3'd0, 8'h00, 6'h00);
        chk("bc_valid", out_valid_a, 6'h3F);
        chk("bc_data", out_data_a, {6{8'h5A}});
        set(1'b0, 3'd0, 8'h00, 6'h3F);
        step();

        // Illegal codes, including saturation of the narrow counter
        p0 = pulses_b;
        for (int i = 0; i < 3; i++) begin
            set(1'b1, 3'd6, 8'hEE, 6'h00);
            chk("ill_rdy", in_ready_a, 1'b1);
            step();
            chk("ill_pulse", err_pulse_a, 1'b1);
        end
        chk("ill_cnt3", err_count_a, 8'd3);
        chk("ill_novalid", out_valid_a, 6'h00);
        step();
        step();
        set(1'b0, 3'd6, 8'h00, 6'h00);
        step();
        chk("ill_cnt5", err_count_a, 8'd5);
        chk("ill_sat", err_count_b, 2'd3);
        step();
        chk("ill_pulse_off", err_pulse_a, 1'b0);
        chk("ill_pulses", pulses_b - p0, 5);

        // Reset while everything is held and stalled
        set(1'b1, 3'd7, 8'h77, 6'h00);
        step();
        set(1'b1, 3'd0, 8'h01, 6'b000001);
        step();
        set(1'b1, 3'd1, 8'h02, 6'b000010);
        step();
        set(1'b0, 3'd0, 8'h00, 6'h00);
        chk("mid_full", out_data_a, {{4{8'h77}}, 8'h02, 8'h01});
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_valid", out_valid_a, 6'h00);
        chk("mid_data", out_data_a, 48'h0);
        chk("mid_err", err_count_a, 8'h00);
        set(1'b1, 3'd1, 8'h9C, 6'h00);
        step();
        set(1'b0, 3'd0, 8'h00, 6'h00);
        chk("post_valid", out_valid_a, 6'b000010);
        chk("post_data", out_data_a[15:8], 8'h9C);

        // Random traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            set(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                8'($urandom), 6'($urandom));
            if (($urandom_range(0, 499)) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            step();
        end
        rst_n = 1'b1;
        set(1'b0, 3'd0, 8'h00, 6'h3F);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1x6_router.md
# demux_1x6_router

Registered 1-to-6 byte router: the distributing counterpart of the design's 6-input selector. It accepts one 8-bit byte per cycle with a 3-bit destination code over a valid/ready handshake. It steers the byte to one of six output channels, or to all six (broadcast), through a one-entry holding register per channel. Illegal destination codes are counted and dropped.

## Interface
- WIDTH, 8: data width of input and of each output channel.
- ERR_W, 8: width of the saturating error counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input byte present.
- in_ready  output  1  router can accept this cycle.
- in_data  input  WIDTH  byte to route.
- in_ctrl  input  3  destination: 0-5 = channel n, 6 = illegal (drop), 7 = broadcast.
- out_valid  output  6  per-channel data held.
- out_ready  input  6  per-channel consumer accepts.
- out_data  output  6*WIDTH  channel n at bits [n*WIDTH+WIDTH-1 : n*WIDTH].
- err_count  output  ERR_W  count of dropped illegal bytes, saturating.
- err_pulse  output  1  one-cycle strobe when an illegal byte is dropped.

## Operation
- Channel n holds at most one byte, tracked by flag full[n], which drives out_valid[n].
- Channel n is free this cycle if !full[n] || out_ready[n].
- in_ready is combinational from in_ctrl, full and out_ready:
  - ctrl 0-5: in_ready = free[ctrl].
  - ctrl 6: in_ready = 1, so the byte is always swallowed.
  - ctrl 7: in_ready = AND of free[0..5].
- Accept occurs when in_valid && in_ready:
  - ctrl 0-5: data[ctrl] <= in_data; full[ctrl] <= 1.
  - ctrl 7: all six data registers load in_data; all full set.
  - ctrl 6: no channel written; err_count increments, holding at all-ones; err_pulse <= 1 next cycle.
- Pop occurs when out_valid[n] && out_ready[n]. On pop with no same-cycle write to n, full[n] <= 0.
- Pop and write to the same channel in one cycle: the new byte loads and full[n] stays 1. This is a back-to-back transfer with no bubble.
- out_data[n] holds stable while out_valid[n] && !out_ready[n]. After a pop it retains its last value; it is not cleared.
- Channels are independent. A stalled channel never blocks traffic addressed to another channel, except a broadcast, which waits for all six.
- A broadcast is all-or-nothing. It is never partially delivered.
- in_ctrl and in_data are don't-care when in_valid = 0. Nothing is written and err_count is unchanged.

## Timing
- Reset values (rst_n sampled low at a rising edge): out_valid = 0, out_data = 0, err_count = 0, err_pulse = 0.
- in_ready during reset is don't-care. It is correct from the first cycle after reset.
- Reset mid-operation discards all held bytes. No out_valid is asserted the cycle after reset.
- Latency: a byte accepted at edge k has out_valid high after edge k; it is visible in cycle k+1.
- Throughput: one byte per cycle per channel when out_ready is held high. Total input throughput is one byte per cycle.
- err_pulse goes high the cycle after an illegal accept and lasts exactly one cycle per illegal byte. Consecutive illegal bytes keep it high continuously.
- err_pulse fires even when err_count is saturated.
- in_ready has no register stage. The upstream must not make in_valid depend combinationally on in_ready.

## Test plan
- Reset then single route: rst_n low 2 cycles, then in_valid=1, ctrl=3, data=8'hA5 for one cycle.
  - Expect: all outputs 0 during reset.
  - Next cycle: out_valid = 6'b001000 and out_data[31:24] = 8'hA5.
  - out_ready[3]=1 for one cycle -> out_valid returns to 0.
- Back-pressure: fill channel 2 with 8'h11 while out_ready[2]=0, then offer ctrl=2, data=8'h22.
  - Expect in_ready=0 and channel 2 holds 8'h11.
  - Raise out_ready[2] -> in_ready=1 in the same cycle; next cycle out_data ch2 = 8'h22 with out_valid[2] still 1.
  - Meanwhile, ctrl=0 traffic is accepted unaffected.
- Streaming: out_ready=6'h3F, send bytes 0..9 to ctrl=5 on consecutive cycles.
  - Expect in_ready=1 every cycle and ch5 emits 0..9 on consecutive cycles, one cycle late, with no gaps.
- Broadcast: channel 4 full and stalled, offer ctrl=7, data=8'h5A.
  - Expect in_ready=0 and no channel changes.
  - Release out_ready[4] -> all six channels hold 8'h5A with out_valid = 6'h3F next cycle.
- Illegal code: 3 consecutive ctrl=6 bytes.
  - Expect in_ready=1, no out_valid change, err_pulse high for 3 cycles, err_count = 3.
  - With ERR_W=2, 5 illegal bytes -> err_count stays 3 and err_pulse fires 5 times.
- Reset mid-operation: channels 0, 1 and 7-broadcast data held and stalled, then assert rst_n low 1 cycle.
  - Expect out_valid=0, out_data=0 and err_count=0 the next cycle.
  - A new ctrl=1 byte routes normally afterwards.
